// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared backend defines for the hazard controller: register-number width,
// logical register range and the hazard FSM state encoding.
package pipe_hazard_ctrl_pkg;

  localparam int REG_W       = 5;
  localparam int LREG_RANGE  = 1 << REG_W;
  localparam int MDCNT_W     = 4;
  localparam int STALL_CNT_W = 32;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_MEM_WAIT   = 2'd1,
    ST_MULDIV     = 2'd2,
    ST_REDIR_PEND = 2'd3
  } hz_state_e;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_cmp.sv
// Load-use comparator: EX load whose destination feeds an ID register source.
module hazard_cmp
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic             ex_valid_i,
  input  logic             ex_is_load_i,
  input  logic             ex_need_to_wb_i,
  input  logic [REG_W-1:0] ex_rd_i,
  input  logic             id_valid_i,
  input  logic             id_src1_is_reg_i,
  input  logic             id_src2_is_reg_i,
  input  logic [REG_W-1:0] id_rs1_i,
  input  logic [REG_W-1:0] id_rs2_i,
  output logic             load_use_o
);

  logic producer;
  logic src_hit;

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign producer = ex_valid_i & ex_is_load_i & ex_need_to_wb_i & (ex_rd_i != '0);
  assign src_hit  = (id_src1_is_reg_i & (id_rs1_i == ex_rd_i)) |
                    (id_src2_is_reg_i & (id_rs2_i == ex_rd_i));
  assign load_use_o = producer & id_valid_i & src_hit;

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait, mul/div occupancy, branch redirect
// and load-use stall/flush generation, plus a fetch-stall cycle counter.
//
// state         | meaning
// ST_RUN        | free flow; evaluate muldiv, redirect, load-use
// ST_MEM_WAIT   | data memory response outstanding
// ST_MULDIV     | mul/div occupying EX, mdcnt counts down to done
// ST_REDIR_PEND | redirect seen while stalled, issue on first free cycle
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int MULDIV_LAT = 4
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   id_valid_i,
  input  logic                   id_src1_is_reg_i,
  input  logic                   id_src2_is_reg_i,
  input  logic [REG_W-1:0]       id_rs1_i,
  input  logic [REG_W-1:0]       id_rs2_i,
  input  logic                   ex_valid_i,
  input  logic                   ex_is_load_i,
  input  logic                   ex_need_to_wb_i,
  input  logic                   ex_is_muldiv_i,
  input  logic [REG_W-1:0]       ex_rd_i,
  input  logic                   ex_redirect_i,
  input  logic                   mem_valid_i,
  input  logic                   mem_is_ls_i,
  input  logic                   mem_resp_valid_i,
  output logic                   stall_ifid_o,
  output logic                   stall_idex_o,
  output logic                   stall_exmem_o,
  output logic                   stall_memwb_o,
  output logic                   flush_ifid_o,
  output logic                   flush_idex_o,
  output logic                   flush_exmem_o,
  output logic                   pc_stall_o,
  output logic                   redirect_take_o,
  output logic                   muldiv_done_o,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  localparam logic [MDCNT_W-1:0] MDCNT_LOAD = MDCNT_W'(MULDIV_LAT - 2);

  hz_state_e              state_q, state_d;
  logic [MDCNT_W-1:0]     mdcnt_q, mdcnt_d;
  logic [STALL_CNT_W-1:0] stall_cycles_q;
  logic                   mem_wait;
  logic                   load_use;
  logic                   redirect_now;

  assign mem_wait     = mem_valid_i & mem_is_ls_i & ~mem_resp_valid_i;
  assign redirect_now = ex_valid_i & ex_redirect_i;

  hazard_cmp u_hazard_cmp (
    .ex_valid_i       (ex_valid_i),
    .ex_is_load_i     (ex_is_load_i),
    .ex_need_to_wb_i  (ex_need_to_wb_i),
    .ex_rd_i          (ex_rd_i),
    .id_valid_i       (id_valid_i),
    .id_src1_is_reg_i (id_src1_is_reg_i),
    .id_src2_is_reg_i (id_src2_is_reg_i),
    .id_rs1_i         (id_rs1_i),
    .id_rs2_i         (id_rs2_i),
    .load_use_o       (load_use)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= ST_RUN;
      mdcnt_q        <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q <= state_d;
      mdcnt_q <= mdcnt_d;
      if (pc_stall_o) stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  always_comb begin
    state_d         = state_q;
    mdcnt_d         = mdcnt_q;
    stall_ifid_o    = 1'b0;
    stall_idex_o    = 1'b0;
    stall_exmem_o   = 1'b0;
    stall_memwb_o   = 1'b0;
    flush_ifid_o    = 1'b0;
    flush_idex_o    = 1'b0;
    flush_exmem_o   = 1'b0;
    pc_stall_o      = 1'b0;
    redirect_take_o = 1'b0;
    muldiv_done_o   = 1'b0;

    if (mem_wait) begin
      stall_ifid_o  = 1'b1;
      stall_idex_o  = 1'b1;
      stall_exmem_o = 1'b1;
      stall_memwb_o = 1'b1;
      pc_stall_o    = 1'b1;
      // A mul/div or an already-latched redirect just holds across the wait.
      if (state_q == ST_RUN || state_q == ST_MEM_WAIT)
        state_d = redirect_now ? ST_REDIR_PEND : ST_MEM_WAIT;
    end else begin
      case (state_q)
        ST_MULDIV: begin
          if (mdcnt_q == '0) begin
            muldiv_done_o = 1'b1;
            state_d       = ST_RUN;
          end else begin
            stall_ifid_o  = 1'b1;
            stall_idex_o  = 1'b1;
            pc_stall_o    = 1'b1;
            flush_exmem_o = 1'b1;
            mdcnt_d       = mdcnt_q - 4'd1;
          end
        end
        ST_REDIR_PEND: begin
          flush_ifid_o    = 1'b1;
          flush_idex_o    = 1'b1;
          redirect_take_o = 1'b1;
          state_d         = ST_RUN;
        end
        default: begin
          state_d = ST_RUN;
          if (ex_valid_i & ex_is_muldiv_i) begin
            stall_ifid_o  = 1'b1;
            stall_idex_o  = 1'b1;
            pc_stall_o    = 1'b1;
            flush_exmem_o = 1'b1;
            mdcnt_d       = MDCNT_LOAD;
            state_d       = ST_MULDIV;
          end else if (redirect_now) begin
            flush_ifid_o    = 1'b1;
            flush_idex_o    = 1'b1;
            redirect_take_o = 1'b1;
          end else if (load_use) begin
            stall_ifid_o = 1'b1;
            pc_stall_o   = 1'b1;
            flush_idex_o = 1'b1;
          end
        end
      endcase
    end

    // Outputs are held quiet for the whole reset window.
    if (!reset_n) begin
      stall_ifid_o    = 1'b0;
      stall_idex_o    = 1'b0;
      stall_exmem_o   = 1'b0;
      stall_memwb_o   = 1'b0;
      flush_ifid_o    = 1'b0;
      flush_idex_o    = 1'b0;
      flush_exmem_o   = 1'b0;
      pc_stall_o      = 1'b0;
      redirect_take_o = 1'b0;
      muldiv_done_o   = 1'b0;
    end
  end

  assign stall_cycles_o = stall_cycles_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int LAT = 4;
  // bit order: sifid sidex sexm smwb fifid fidex fexm pc take done
  localparam logic [9:0] V_IDLE = 10'b0000000000;
  localparam logic [9:0] V_LU   = 10'b1000010100;
  localparam logic [9:0] V_MW   = 10'b1111000100;
  localparam logic [9:0] V_MD   = 10'b1100001100;
  localparam logic [9:0] V_DONE = 10'b0000000001;
  localparam logic [9:0] V_RD   = 10'b0000110010;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic id_valid, id_src1_is_reg, id_src2_is_reg;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic ex_valid, ex_is_load, ex_need_to_wb, ex_is_muldiv, ex_redirect;
  logic mem_valid, mem_is_ls, mem_resp_valid;
  logic stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic flush_ifid, flush_idex, flush_exmem;
  logic pc_stall, redirect_take, muldiv_done;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;
  bit run_cmp = 1'b1;

  always #5 clock = ~clock;

  pipe_hazard_ctrl #(.MULDIV_LAT(LAT)) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .id_valid_i       (id_valid),
    .id_src1_is_reg_i (id_src1_is_reg),
    .id_src2_is_reg_i (id_src2_is_reg),
    .id_rs1_i         (id_rs1),
    .id_rs2_i         (id_rs2),
    .ex_valid_i       (ex_valid),
    .ex_is_load_i     (ex_is_load),
    .ex_need_to_wb_i  (ex_need_to_wb),
    .ex_is_muldiv_i   (ex_is_muldiv),
    .ex_rd_i          (ex_rd),
    .ex_redirect_i    (ex_redirect),
    .mem_valid_i      (mem_valid),
    .mem_is_ls_i      (mem_is_ls),
    .mem_resp_valid_i (mem_resp_valid),
    .stall_ifid_o     (stall_ifid),
    .stall_idex_o     (stall_idex),
    .stall_exmem_o    (stall_exmem),
    .stall_memwb_o    (stall_memwb),
    .flush_ifid_o     (flush_ifid),
    .flush_idex_o     (flush_idex),
    .flush_exmem_o    (flush_exmem),
    .pc_stall_o       (pc_stall),
    .redirect_take_o  (redirect_take),
    .muldiv_done_o    (muldiv_done),
    .stall_cycles_o   (stall_cycles)
  );

  logic [9:0] dut_vec;
  assign dut_vec = {stall_ifid, stall_idex, stall_exmem, stall_memwb, flush_ifid,
                    flush_idex, flush_exmem, pc_stall, redirect_take, muldiv_done};

  // Reference model: EX occupancy cycles left, latched redirect, stall count.
  int         md_left = 0;
  bit         pend = 1'b0;
  logic [31:0] m_stalls = 32'd0;
  logic [9:0] exp_vec;
  int         nxt_md;
  bit         nxt_pend;
  logic       mw, lu;

  always @* begin
    exp_vec  = V_IDLE;
    nxt_md   = md_left;
    nxt_pend = pend;
    mw = mem_valid && mem_is_ls && !mem_resp_valid;
    lu = ex_valid && ex_is_load && ex_need_to_wb && ex_rd != 5'd0 && id_valid &&
         ((id_src1_is_reg && id_rs1 == ex_rd) || (id_src2_is_reg && id_rs2 == ex_rd));
    if (!reset_n) begin
      nxt_md   = 0;
      nxt_pend = 1'b0;
    end else if (mw) begin
      exp_vec = V_MW;
      if (md_left == 0 && ex_valid && ex_redirect) nxt_pend = 1'b1;
    end else if (md_left > 1) begin
      exp_vec = V_MD;
      nxt_md  = md_left - 1;
    end else if (md_left == 1) begin
      exp_vec = V_DONE;
      nxt_md  = 0;
    end else if (pend) begin
      exp_vec  = V_RD;
      nxt_pend = 1'b0;
    end else if (ex_valid && ex_is_muldiv) begin
      exp_vec = V_MD;
      nxt_md  = LAT - 1;
    end else if (ex_valid && ex_redirect) begin
      exp_vec = V_RD;
    end else if (lu) begin
      exp_vec = V_LU;
    end
  end

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      md_left  <= 0;
      pend     <= 1'b0;
      m_stalls <= 32'd0;
    end else begin
      md_left <= nxt_md;
      pend    <= nxt_pend;
      if (exp_vec[2]) m_stalls <= m_stalls + 32'd1;
    end
  end

  always @(negedge clock) begin
    if (run_cmp) begin
      checks++;
      if (dut_vec !== exp_vec || stall_cycles !== m_stalls) begin
        errors++;
        $display("FAIL model_cycle t=%0t: dut=%b/%0d exp=%b/%0d",
                 $time, dut_vec, stall_cycles, exp_vec, m_stalls);
      end
    end
  end

  task automatic idle();
    id_valid = 0; id_src1_is_reg = 0; id_src2_is_reg = 0; id_rs1 = 0; id_rs2 = 0;
    ex_valid = 0; ex_is_load = 0; ex_need_to_wb = 0; ex_is_muldiv = 0; ex_rd = 0;
    ex_redirect = 0; mem_valid = 0; mem_is_ls = 0; mem_resp_valid = 0;
  endtask

  task automatic step(input string nm, input logic [9:0] exp);
    @(negedge clock);
    checks++;
    if (dut_vec !== exp) begin
      errors++;
      $display("FAIL %s: dut=%b exp=%b", nm, dut_vec, exp);
    end
    @(posedge clock);
    #1;
  endtask

  task automatic chk_cnt(input string nm, input logic [31:0] exp);
    checks++;
    if (stall_cycles !== exp) begin
      errors++;
      $display("FAIL %s: stall_cycles=%0d exp=%0d", nm, stall_cycles, exp);
    end
  endtask

  task automatic ld_ex(input logic [4:0] rd);
    ex_valid = 1; ex_is_load = 1; ex_need_to_wb = 1; ex_rd = rd;
  endtask

  initial begin
    idle();
    mem_valid = 1; mem_is_ls = 1;
    step("reset_outs", V_IDLE);
    chk_cnt("reset_cnt", 32'd0);
    idle(); reset_n = 1;
    step("idle", V_IDLE);

    ld_ex(5'd5); id_valid = 1; id_src1_is_reg = 1; id_rs1 = 5'd5; id_rs2 = 5'd9;
    step("lu_rs1", V_LU);
    ex_valid = 0;
    step("lu_free_flow", V_IDLE);
    idle(); ld_ex(5'd7); id_valid = 1; id_rs1 = 5'd7; id_src2_is_reg = 1; id_rs2 = 5'd3;
    step("lu_src1_not_reg", V_IDLE);
    id_rs2 = 5'd7;
    step("lu_rs2", V_LU);
    idle(); ld_ex(5'd0); id_valid = 1; id_src1_is_reg = 1; id_src2_is_reg = 1;
    step("lu_x0", V_IDLE);
    idle(); ld_ex(5'd5); ex_need_to_wb = 0; id_valid = 1; id_src1_is_reg = 1; id_rs1 = 5'd5;
    step("lu_no_wb", V_IDLE);

    idle(); ex_valid = 1; ex_is_muldiv = 1;
    step("md_c1", V_MD);
    step("md_c2", V_MD);
    step("md_c3", V_MD);
    step("md_done", V_DONE);
    idle();
    step("md_after", V_IDLE);
    chk_cnt("cnt_after_md", 32'd5);

    mem_valid = 1; mem_is_ls = 1;
    step("mw_c1", V_MW);
    step("mw_c2", V_MW);
    step("mw_c3", V_MW);
    mem_resp_valid = 1;
    step("mw_resp", V_IDLE);
    idle();
    chk_cnt("cnt_after_mw", 32'd8);

    mem_valid = 1; mem_is_ls = 1; ex_valid = 1; ex_redirect = 1;
    step("rp_hold1", V_MW);
    step("rp_hold2", V_MW);
    mem_resp_valid = 1;
    step("rp_fire", V_RD);
    idle();
    step("rp_once", V_IDLE);

    ld_ex(5'd5); ex_redirect = 1; id_valid = 1; id_src1_is_reg = 1; id_rs1 = 5'd5;
    step("rd_beats_lu", V_RD);

    idle(); ex_valid = 1; ex_is_muldiv = 1; mem_valid = 1; mem_is_ls = 1;
    step("mw_beats_md", V_MW);
    mem_resp_valid = 1;
    step("md_entry_after_mw", V_MD);
    mem_valid = 0; mem_resp_valid = 0;
    step("md2_c2", V_MD);
    step("md2_c3", V_MD);
    step("md2_done", V_DONE);
    idle();

    ex_valid = 1; ex_is_muldiv = 1;
    step("md3_c1", V_MD);
    step("md3_c2", V_MD);
    reset_n = 0;
    step("rst_mid_md", V_IDLE);
    chk_cnt("rst_cnt", 32'd0);
    idle(); reset_n = 1;
    step("rst_md_post1", V_IDLE);
    step("rst_md_post2", V_IDLE);

    mem_valid = 1; mem_is_ls = 1; ex_valid = 1; ex_redirect = 1;
    step("rp2_hold", V_MW);
    reset_n = 0; idle();
    step("rst_mid_rp", V_IDLE);
    reset_n = 1;
    step("rst_rp_post1", V_IDLE);
    step("rst_rp_post2", V_IDLE);

    run_cmp = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
